banderin_ctrl: RTL and testbench

BANDERIN_CTRL -- requirements
Module: banderin_ctrl

---
 rtl/banderin_pkg.sv | 14 +
 rtl/banderin_ctrl_antirrebote.sv | 34 +++
 rtl/banderin_ctrl.sv | 83 ++++++++
 tb/tb_banderin_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/banderin_pkg.sv
// banderin_pkg: FSM state encoding and default timing constants for the race flag controller
package banderin_pkg;
  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    ARMADO  = 2'd1,
    CARRERA = 2'd2,
    FIN     = 2'd3
  } estado_t;
  localparam int unsigned CLK_FREQ_HZ_DEF   = 25_000_000;
  localparam int unsigned DEBOUNCE_CLKS_DEF = 250_000;
  localparam int unsigned MIN_LAP_CLKS_DEF  = 25_000_000;
  localparam int unsigned HOLD_CLKS_DEF     = 50_000_000;
  localparam int unsigned MAX_RACE_CLKS_DEF = 1_500_000_000;
endpackage

// File: rtl/banderin_ctrl_antirrebote.sv
// antirrebote: 2-FF synchronizer, level debouncer and rising-edge strobe for one async input
module antirrebote
  import banderin_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CLKS = DEBOUNCE_CLKS_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic entrada,
  output logic pulso
);
  localparam logic [31:0] LIMITE = 32'(DEBOUNCE_CLKS - 1);
  logic [1:0]  sync;
  logic [31:0] cnt;
  logic        nivel, nivel_d;
  // synchronize, then accept a new level only after enough consecutive differing samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync    <= '0;
      cnt     <= '0;
      nivel   <= 1'b0;
      nivel_d <= 1'b0;
    end else begin
      sync    <= {sync[0], entrada};
      nivel_d <= nivel;
      if (sync[1] == nivel) cnt <= '0;
      else if (cnt == LIMITE) begin
        cnt   <= '0;
        nivel <= sync[1];
      end else cnt <= cnt + 32'd1;
    end
  end
  assign pulso = nivel & ~nivel_d;
endmodule

// File: rtl/banderin_ctrl.sv
// banderin_ctrl: race start/finish flag controller; define BANDERIN_TIMEOUT_EN to end races after MAX_RACE_CLKS
module banderin_ctrl
  import banderin_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = CLK_FREQ_HZ_DEF,
  parameter int unsigned DEBOUNCE_CLKS = DEBOUNCE_CLKS_DEF,
  parameter int unsigned MIN_LAP_CLKS  = MIN_LAP_CLKS_DEF,
  parameter int unsigned HOLD_CLKS     = HOLD_CLKS_DEF,
  parameter int unsigned MAX_RACE_CLKS = MAX_RACE_CLKS_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       boton_armar,
  input  logic       sensor_paso,
  output logic       comando_banderin,
  output logic       carrera_activa,
  output logic       evento_inicio,
  output logic       evento_fin,
  output logic [1:0] estado
);
  localparam logic [63:0] unused_cfg = {CLK_FREQ_HZ, MAX_RACE_CLKS};
  localparam logic [31:0] MIN_LAP = 32'(MIN_LAP_CLKS);
  localparam logic [31:0] HOLD_FIN = 32'(HOLD_CLKS - 1);
  estado_t     estado_q, estado_sig;
  logic        arm, sen, ini, fin;
  logic [31:0] cnt_carrera, cnt_fin;
  antirrebote #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_arm (
    .clk(clk), .reset_n(reset_n), .entrada(boton_armar), .pulso(arm)
  );
  antirrebote #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_sen (
    .clk(clk), .reset_n(reset_n), .entrada(sensor_paso), .pulso(sen)
  );
  // next state: arm strobe always wins, finish needs the minimum lap time
  always_comb begin
    estado_sig = estado_q;
    ini = 1'b0;
    fin = 1'b0;
    unique case (estado_q)
      REPOSO: estado_sig = arm ? ARMADO : REPOSO;
      ARMADO:
        if (arm) estado_sig = REPOSO;
        else if (sen) begin
          estado_sig = CARRERA;
          ini = 1'b1;
        end
      CARRERA:
        if (arm) estado_sig = REPOSO;
        else if (sen && cnt_carrera >= MIN_LAP) begin
          estado_sig = FIN;
          fin = 1'b1;
        end
`ifdef BANDERIN_TIMEOUT_EN
        else if (cnt_carrera >= 32'(MAX_RACE_CLKS)) begin
          estado_sig = FIN;
          fin = 1'b1;
        end
`endif
      FIN: estado_sig = (cnt_fin == HOLD_FIN) ? REPOSO : FIN;
      default: estado_sig = REPOSO;
    endcase
  end
  // state, counters and registered outputs derived from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q         <= REPOSO;
      cnt_carrera      <= '0;
      cnt_fin          <= '0;
      comando_banderin <= 1'b0;
      carrera_activa   <= 1'b0;
      evento_inicio    <= 1'b0;
      evento_fin       <= 1'b0;
    end else begin
      estado_q         <= estado_sig;
      cnt_carrera      <= (estado_q != CARRERA) ? '0 : (&cnt_carrera) ? cnt_carrera : cnt_carrera + 32'd1;
      cnt_fin          <= (estado_q == FIN) ? cnt_fin + 32'd1 : '0;
      comando_banderin <= (estado_sig == ARMADO) || (estado_sig == FIN);
      carrera_activa   <= estado_sig == CARRERA;
      evento_inicio    <= ini;
      evento_fin       <= fin;
    end
  end
  assign estado = estado_q;
endmodule

// File: tb/tb_banderin_ctrl.sv
// tb_banderin_ctrl: directed-vector bench for banderin_ctrl with short timing parameters
module tb_banderin_ctrl;
  logic       clk = 1'b0, reset_n = 1'b0, boton_armar = 1'b0, sensor_paso = 1'b0;
  logic       comando_banderin, carrera_activa, evento_inicio, evento_fin;
  logic [1:0] estado;
  int n_vec = 0, n_err = 0, n_ini = 0, n_fin = 0;
  always #5 clk = ~clk;
  banderin_ctrl #(
    .DEBOUNCE_CLKS(4), .MIN_LAP_CLKS(20), .HOLD_CLKS(10), .MAX_RACE_CLKS(50)
  ) dut (
    .clk(clk), .reset_n(reset_n), .boton_armar(boton_armar), .sensor_paso(sensor_paso),
    .comando_banderin(comando_banderin), .carrera_activa(carrera_activa),
    .evento_inicio(evento_inicio), .evento_fin(evento_fin), .estado(estado)
  );
  // tally event pulses, one per high cycle
  always @(negedge clk) begin
    if (evento_inicio) n_ini <= n_ini + 1;
    if (evento_fin) n_fin <= n_fin + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic armar();
    boton_armar = 1'b1;
    tick(6);
    boton_armar = 1'b0;
    chk("arm_latency", estado, 0);
    tick(1);
    chk("armed_state", estado, 1);
    chk("armed_flag", comando_banderin, 1);
    tick(8);
  endtask
  task automatic salir();
    sensor_paso = 1'b1;
    tick(6);
    sensor_paso = 1'b0;
    chk("start_latency", evento_inicio, 0);
    tick(1);
    chk("start_state", estado, 2);
    chk("start_pulse", evento_inicio, 1);
    chk("start_flag", comando_banderin, 0);
    chk("start_active", carrera_activa, 1);
  endtask
  initial begin
    tick(2);
    chk("rst_estado", estado, 0);
    chk("rst_flag", comando_banderin, 0);
    chk("rst_active", carrera_activa, 0);
    chk("rst_events", {evento_inicio, evento_fin}, 0);
    reset_n = 1'b1;
    tick(2);
    boton_armar = 1'b1;
    tick(2);
    boton_armar = 1'b0;
    tick(10);
    chk("glitch_estado", estado, 0);
    chk("glitch_flag", comando_banderin, 0);
    armar();
    salir();
    tick(1);
    chk("start_one_cycle", evento_inicio, 0);
    tick(3);
    sensor_paso = 1'b1;
    tick(6);
    sensor_paso = 1'b0;
    tick(3);
    chk("early_cross_estado", estado, 2);
    chk("early_cross_nofin", n_fin, 0);
    tick(6);
    sensor_paso = 1'b1;
    tick(6);
    sensor_paso = 1'b0;
    chk("finish_latency", estado, 2);
    tick(1);
    chk("finish_estado", estado, 3);
    chk("finish_pulse", evento_fin, 1);
    chk("finish_flag", comando_banderin, 1);
    chk("finish_inactive", carrera_activa, 0);
    tick(9);
    chk("hold_estado", estado, 3);
    tick(1);
    chk("hold_done_estado", estado, 0);
    chk("hold_done_flag", comando_banderin, 0);
    chk("race1_ini_count", n_ini, 1);
    chk("race1_fin_count", n_fin, 1);
    tick(5);
    armar();
    boton_armar = 1'b1;
    sensor_paso = 1'b1;
    tick(6);
    boton_armar = 1'b0;
    sensor_paso = 1'b0;
    tick(1);
    chk("simul_estado", estado, 0);
    chk("simul_flag", comando_banderin, 0);
    chk("simul_no_ini", n_ini, 1);
    tick(8);
    armar();
    salir();
    tick(15);
    #2 reset_n = 1'b0;
    #1;
    chk("midrace_rst_estado", estado, 0);
    chk("midrace_rst_flag", comando_banderin, 0);
    chk("midrace_rst_active", carrera_activa, 0);
    chk("midrace_rst_events", {evento_inicio, evento_fin}, 0);
    tick(2);
    reset_n = 1'b1;
    tick(10);
    chk("post_rst_estado", estado, 0);
    armar();
    salir();
`ifdef BANDERIN_TIMEOUT_EN
    tick(50);
    chk("timeout_before", estado, 2);
    tick(1);
    chk("timeout_estado", estado, 3);
    chk("timeout_pulse", evento_fin, 1);
    tick(10);
    chk("timeout_hold_done", estado, 0);
    chk("timeout_fin_count", n_fin, 2);
`else
    tick(110);
    chk("no_timeout_estado", estado, 2);
    chk("no_timeout_active", carrera_activa, 1);
    chk("no_timeout_fin_count", n_fin, 1);
    boton_armar = 1'b1;
    tick(6);
    boton_armar = 1'b0;
    tick(1);
    chk("abort_estado", estado, 0);
    chk("abort_active", carrera_activa, 0);
    tick(2);
    chk("abort_no_fin", n_fin, 1);
`endif
    chk("total_ini_count", n_ini, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
